mmc1_sync_mapper: RTL and testbench

MMC1_SYNC_MAPPER -- requirements
Module: mmc1_sync_mapper

---
 rtl/mmc1_pkg.sv | 36 +++
 rtl/mmc1_bus_sync.sv | 53 +++++
 rtl/mmc1_sync_mapper.sv | 160 ++++++++++++++++
 tb/tb_mmc1_sync_mapper.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_pkg.sv
// Shared encodings for the MMC1-style serial mapper: register selects, control fields, bus capture.
package mmc1_pkg;

  typedef enum logic [1:0] {
    SEL_CONTROL = 2'b00,
    SEL_CHR0    = 2'b01,
    SEL_CHR1    = 2'b10,
    SEL_PRG     = 2'b11
  } reg_sel_e;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'b00,
    MIR_ONE_HI = 2'b01,
    MIR_VERT   = 2'b10,
    MIR_HORZ   = 2'b11
  } mirror_e;

  typedef enum logic [1:0] {
    PRG_32K_A     = 2'b00,
    PRG_32K_B     = 2'b01,
    PRG_FIX_FIRST = 2'b10,
    PRG_FIX_LAST  = 2'b11
  } prg_mode_e;

  localparam logic [7:0] CONTROL_RESET = 8'h0C;

  typedef struct packed {
    logic a14;
    logic a13;
    logic romsel_n;
    logic rw_n;
    logic d0;
    logic d7;
  } bus_cap_t;

endpackage

// File: rtl/mmc1_bus_sync.sv
// Synchronises the CPU bus into the mapper clock, latches fields while M2 is high and
// strobes cycle_end_o on the first clock where synchronised M2 has fallen.
module mmc1_bus_sync
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     m2_i,
  input  logic     a13_i,
  input  logic     a14_i,
  input  logic     romsel_n_i,
  input  logic     rw_n_i,
  input  logic     d0_i,
  input  logic     d7_i,
  output logic     cycle_end_o,
  output bus_cap_t cap_o
);

  bus_cap_t                 raw;
  logic [SYNC_STAGES-1:0]   m2_sync_q;
  bus_cap_t                 cap_sync_q [SYNC_STAGES];
  bus_cap_t                 cap_q;
  logic                     m2_prev_q;
  logic                     m2_s;

  assign raw  = {a14_i, a13_i, romsel_n_i, rw_n_i, d0_i, d7_i};
  assign m2_s = m2_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m2_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) cap_sync_q[i] <= '0;
      cap_q     <= '0;
      m2_prev_q <= 1'b0;
    end else begin
      m2_sync_q[0]  <= m2_i;
      cap_sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        m2_sync_q[i]  <= m2_sync_q[i-1];
        cap_sync_q[i] <= cap_sync_q[i-1];
      end
      m2_prev_q <= m2_s;
      // Keep refreshing while M2 is high so the last value before the fall is held.
      if (m2_s) cap_q <= cap_sync_q[SYNC_STAGES-1];
    end
  end

  assign cycle_end_o = m2_prev_q & ~m2_s;
  assign cap_o       = cap_q;

endmodule

// File: rtl/mmc1_sync_mapper.sv
// MMC1-style serial-load mapper: filtered 5-bit shift loading of control/CHR/PRG registers,
// with combinational bank, mirroring and chip-enable decode from the raw bus pins.
module mmc1_sync_mapper
  import mmc1_pkg::*;
#(
  parameter int SHIFT_LEN   = 5,
  parameter int PRG_OUT_W   = 4,
  parameter int CHR_OUT_W   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 CPU_M2,
  input  logic                 CPU_A13,
  input  logic                 CPU_A14,
  input  logic                 nCPU_ROMSEL,
  input  logic                 nCPU_RW,
  input  logic                 CPU_D0,
  input  logic                 CPU_D7,
  input  logic                 PPU_A12,
  input  logic                 PPU_A11,
  input  logic                 PPU_A10,
  output logic [PRG_OUT_W-1:0] PRG_A,
  output logic [CHR_OUT_W-1:0] CHR_A,
  output logic                 CIRAM_A10,
  output logic                 nPRG_CE,
  output logic                 nWRAM_CE,
  output logic                 REG_COMMIT,
  output logic [1:0]           REG_SEL
);

  localparam int CW = $clog2(SHIFT_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_LEN - 1);
  localparam logic [SHIFT_LEN-1:0] CTRL_RST = SHIFT_LEN'(CONTROL_RESET);

  logic                 cycle_end;
  bus_cap_t             cap;
  logic                 is_wr;
  logic [SHIFT_LEN-1:0] shifted;

  logic [CW-1:0]        count_q, count_d;
  logic [SHIFT_LEN-1:0] shift_q, shift_d;
  logic [SHIFT_LEN-1:0] ctrl_q, ctrl_d, chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d;
  logic                 last_wr_q, last_wr_d;
  logic                 commit_q, commit_d;
  reg_sel_e             sel_q, sel_d;

  mmc1_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk_i       (CLK),
    .rst_n_i     (nRST),
    .m2_i        (CPU_M2),
    .a13_i       (CPU_A13),
    .a14_i       (CPU_A14),
    .romsel_n_i  (nCPU_ROMSEL),
    .rw_n_i      (nCPU_RW),
    .d0_i        (CPU_D0),
    .d7_i        (CPU_D7),
    .cycle_end_o (cycle_end),
    .cap_o       (cap)
  );

  assign is_wr   = ~cap.romsel_n & ~cap.rw_n;
  // The shifter fills from the top, so after SHIFT_LEN-1 bits the first one sits at bit 1.
  assign shifted = {cap.d0, shift_q[SHIFT_LEN-1:1]};

  always_comb begin
    count_d   = count_q;
    shift_d   = shift_q;
    ctrl_d    = ctrl_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    last_wr_d = last_wr_q;
    commit_d  = 1'b0;
    sel_d     = sel_q;
    if (cycle_end) begin
      last_wr_d = is_wr;
      if (is_wr && !last_wr_q) begin
        if (cap.d7) begin
          count_d     = '0;
          shift_d     = '0;
          ctrl_d[3:2] = 2'b11;
        end else if (count_q != LAST_CNT) begin
          shift_d = shifted;
          count_d = count_q + CW'(1);
        end else begin
          count_d  = '0;
          shift_d  = '0;
          commit_d = 1'b1;
          sel_d    = reg_sel_e'({cap.a14, cap.a13});
          case (reg_sel_e'({cap.a14, cap.a13}))
            SEL_CONTROL: ctrl_d = shifted;
            SEL_CHR0:    chr0_d = shifted;
            SEL_CHR1:    chr1_d = shifted;
            default:     prg_d  = shifted;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q   <= '0;
      shift_q   <= '0;
      ctrl_q    <= CTRL_RST;
      chr0_q    <= '0;
      chr1_q    <= '0;
      prg_q     <= '0;
      last_wr_q <= 1'b0;
      commit_q  <= 1'b0;
      sel_q     <= SEL_CONTROL;
    end else begin
      count_q   <= count_d;
      shift_q   <= shift_d;
      ctrl_q    <= ctrl_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
      last_wr_q <= last_wr_d;
      commit_q  <= commit_d;
      sel_q     <= sel_d;
    end
  end

  assign REG_COMMIT = commit_q;
  assign REG_SEL    = sel_q;

  logic [PRG_OUT_W-1:0] bank;
  logic                 wram_dis;
  logic                 unused_bits;

  assign bank        = prg_q[PRG_OUT_W-1:0];
  assign wram_dis    = prg_q[SHIFT_LEN-1];
  assign unused_bits = ^{ctrl_q, chr0_q, chr1_q, prg_q};

  always_comb begin
    CIRAM_A10 = 1'b0;
    case (mirror_e'(ctrl_q[1:0]))
      MIR_ONE_LO: CIRAM_A10 = 1'b0;
      MIR_ONE_HI: CIRAM_A10 = 1'b1;
      MIR_VERT:   CIRAM_A10 = PPU_A10;
      default:    CIRAM_A10 = PPU_A11;
    endcase

    PRG_A = bank;
    case (prg_mode_e'(ctrl_q[3:2]))
      PRG_FIX_FIRST: PRG_A = CPU_A14 ? bank : '0;
      PRG_FIX_LAST:  PRG_A = CPU_A14 ? {PRG_OUT_W{1'b1}} : bank;
      default:       PRG_A = {bank[PRG_OUT_W-1:1], CPU_A14};
    endcase

    if (ctrl_q[4]) CHR_A = PPU_A12 ? chr1_q[CHR_OUT_W-1:0] : chr0_q[CHR_OUT_W-1:0];
    else           CHR_A = {chr0_q[CHR_OUT_W-1:1], PPU_A12};
  end

  assign nPRG_CE  = nCPU_ROMSEL | ~nCPU_RW;
  assign nWRAM_CE = ~(CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & ~wram_dis);

endmodule

// File: tb/tb_mmc1_sync_mapper.sv
// Directed bench for mmc1_sync_mapper: serial loads, write filtering, reset and decode paths.
module tb_mmc1_sync_mapper;

  logic CLK = 1'b0;
  logic nRST, CPU_M2, CPU_A13, CPU_A14, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7;
  logic PPU_A12, PPU_A11, PPU_A10;
  logic [3:0] PRG_A;
  logic [4:0] CHR_A;
  logic CIRAM_A10, nPRG_CE, nWRAM_CE, REG_COMMIT;
  logic [1:0] REG_SEL;

  logic [5:0] PRG_A7;
  logic [4:0] CHR_A7;
  logic CIRAM_A10_7, nPRG_CE_7, nWRAM_CE_7, REG_COMMIT_7;
  logic [1:0] REG_SEL_7;

  int n_tests = 0;
  int n_fail  = 0;
  int n_commit = 0;
  int c0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (REG_COMMIT === 1'b1) n_commit <= n_commit + 1;

  mmc1_sync_mapper dut (
    .CLK(CLK), .nRST(nRST), .CPU_M2(CPU_M2), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
    .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
    .PPU_A12(PPU_A12), .PPU_A11(PPU_A11), .PPU_A10(PPU_A10),
    .PRG_A(PRG_A), .CHR_A(CHR_A), .CIRAM_A10(CIRAM_A10), .nPRG_CE(nPRG_CE),
    .nWRAM_CE(nWRAM_CE), .REG_COMMIT(REG_COMMIT), .REG_SEL(REG_SEL)
  );

  mmc1_sync_mapper #(.SHIFT_LEN(7), .PRG_OUT_W(6)) dut7 (
    .CLK(CLK), .nRST(nRST), .CPU_M2(CPU_M2), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
    .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
    .PPU_A12(PPU_A12), .PPU_A11(PPU_A11), .PPU_A10(PPU_A10),
    .PRG_A(PRG_A7), .CHR_A(CHR_A7), .CIRAM_A10(CIRAM_A10_7), .nPRG_CE(nPRG_CE_7),
    .nWRAM_CE(nWRAM_CE_7), .REG_COMMIT(REG_COMMIT_7), .REG_SEL(REG_SEL_7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input logic a14, input logic a13, input logic romsel_n,
                           input logic rw_n, input logic d0, input logic d7);
    @(negedge CLK);
    CPU_A14 = a14; CPU_A13 = a13; nCPU_ROMSEL = romsel_n; nCPU_RW = rw_n;
    CPU_D0 = d0; CPU_D7 = d7;
    CPU_M2 = 1'b1;
    repeat (4) @(negedge CLK);
    CPU_M2 = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  // A write followed by an unrelated read, so the consecutive-write filter stays clear.
  task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7);
    bus_cycle(a14, a13, 1'b0, 1'b0, d0, d7);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load5(input logic a14, input logic a13, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a14, a13, v[i], 1'b0);
  endtask

  task automatic set_ppu(input logic a12, input logic a11, input logic a10);
    PPU_A12 = a12; PPU_A11 = a11; PPU_A10 = a10;
    #1;
  endtask

  task automatic set_a14(input logic a14);
    CPU_A14 = a14;
    #1;
  endtask

  initial begin
    nRST = 1'b0; CPU_M2 = 1'b0; CPU_A13 = 1'b0; CPU_A14 = 1'b0;
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
    PPU_A12 = 1'b0; PPU_A11 = 1'b0; PPU_A10 = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    set_a14(1'b1);
    check("rst_prg_hi", PRG_A, 4'hF);
    check("rst_prg7_hi", PRG_A7, 6'h3F);
    set_a14(1'b0);
    check("rst_prg_lo", PRG_A, 4'h0);
    set_ppu(1'b1, 1'b1, 1'b1);
    check("rst_chr", CHR_A, 5'h01);
    check("rst_ciram", CIRAM_A10, 1'b0);
    check("rst_commit", REG_COMMIT, 1'b0);
    check("rst_sel", REG_SEL, 2'd0);
    nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b1; #1;
    check("prgce_read", nPRG_CE, 1'b0);
    nCPU_RW = 1'b0; #1;
    check("prgce_write", nPRG_CE, 1'b1);
    CPU_M2 = 1'b1; nCPU_ROMSEL = 1'b1; CPU_A14 = 1'b1; CPU_A13 = 1'b1; nCPU_RW = 1'b1; #1;
    check("wram_en_rst", nWRAM_CE, 1'b0);
    CPU_M2 = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // PRG load at $E000: bits 0,1,1,0,1 -> 0x16
    c0 = n_commit;
    load5(1'b1, 1'b1, 5'b10110);
    check("s1_commit_once", n_commit - c0, 1);
    check("s1_sel", REG_SEL, 2'd3);
    CPU_M2 = 1'b1; nCPU_ROMSEL = 1'b1; CPU_A14 = 1'b1; CPU_A13 = 1'b1; #1;
    check("s1_wram_dis", nWRAM_CE, 1'b1);
    CPU_M2 = 1'b0;
    set_a14(1'b0);
    check("s1_prg_8000", PRG_A, 4'h6);
    set_a14(1'b1);
    check("s1_prg_c000", PRG_A, 4'hF);

    // Back-to-back write is dropped; four more bits complete control = 0x01
    c0 = n_commit;
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wr(1'b0, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 1'b0, 1'b0, 1'b0);
    wr(1'b0, 1'b0, 1'b0, 1'b0);
    check("s2_no_early_commit", n_commit - c0, 0);
    wr(1'b0, 1'b0, 1'b0, 1'b0);
    check("s2_commit", n_commit - c0, 1);
    check("s2_sel", REG_SEL, 2'd0);
    set_ppu(1'b0, 1'b0, 1'b0);
    check("s2_ciram_one_hi", CIRAM_A10, 1'b1);
    set_a14(1'b1);
    check("s2_prg_32k_hi", PRG_A, 4'h7);

    // Partial load, D7 reset, then control = 0x00
    c0 = n_commit;
    wr(1'b0, 1'b0, 1'b1, 1'b0);
    wr(1'b0, 1'b0, 1'b1, 1'b0);
    wr(1'b0, 1'b0, 1'b1, 1'b0);
    wr(1'b0, 1'b0, 1'b0, 1'b1);
    check("s3_d7_no_commit", n_commit - c0, 0);
    set_a14(1'b1);
    check("s3_d7_mode11", PRG_A, 4'hF);
    check("s3_d7_mir_kept", CIRAM_A10, 1'b1);
    load5(1'b0, 1'b0, 5'h00);
    check("s3_commit", n_commit - c0, 1);
    set_ppu(1'b0, 1'b1, 1'b1);
    check("s3_ciram_zero", CIRAM_A10, 1'b0);
    set_a14(1'b0);
    check("s3_prg32_lo", PRG_A, 4'h6);
    set_a14(1'b1);
    check("s3_prg32_hi", PRG_A, 4'h7);

    // CHR banking, 8K then 4K, and the PPU-driven mirroring modes
    load5(1'b0, 1'b1, 5'h03);
    set_ppu(1'b0, 1'b0, 1'b0);
    check("s4_chr8k_lo", CHR_A, 5'h02);
    set_ppu(1'b1, 1'b0, 1'b0);
    check("s4_chr8k_hi", CHR_A, 5'h03);
    load5(1'b1, 1'b0, 5'h1E);
    load5(1'b0, 1'b0, 5'h10);
    set_ppu(1'b0, 1'b0, 1'b0);
    check("s4_chr4k_lo", CHR_A, 5'h03);
    set_ppu(1'b1, 1'b0, 1'b0);
    check("s4_chr4k_hi", CHR_A, 5'h1E);
    load5(1'b0, 1'b0, 5'h12);
    set_ppu(1'b0, 1'b0, 1'b1);
    check("s4_mir_vert_1", CIRAM_A10, 1'b1);
    set_ppu(1'b0, 1'b1, 1'b0);
    check("s4_mir_vert_0", CIRAM_A10, 1'b0);
    load5(1'b0, 1'b0, 5'h13);
    set_ppu(1'b0, 1'b1, 1'b0);
    check("s4_mir_horz_1", CIRAM_A10, 1'b1);
    set_ppu(1'b0, 1'b0, 1'b1);
    check("s4_mir_horz_0", CIRAM_A10, 1'b0);

    // Reset after two shifts, last cycle a write; new load of 0x19 to $E000
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    set_a14(1'b1);
    check("s5_rst_prg", PRG_A, 4'hF);
    set_ppu(1'b1, 1'b1, 1'b1);
    check("s5_rst_chr", CHR_A, 5'h01);
    check("s5_rst_ciram", CIRAM_A10, 1'b0);
    c0 = n_commit;
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    wr(1'b1, 1'b1, 1'b0, 1'b0);
    wr(1'b1, 1'b1, 1'b0, 1'b0);
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    check("s5_no_early_commit", n_commit - c0, 0);
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    check("s5_commit", n_commit - c0, 1);
    check("s5_sel", REG_SEL, 2'd3);
    set_a14(1'b0);
    check("s5_prg_8000", PRG_A, 4'h9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
